ifid_queue: RTL and testbench

IFID_QUEUE -- requirements
Module: ifid_queue

---
 rtl/ifid_queue_if.sv | 22 ++
 rtl/ifid_queue.sv | 56 +++++
 tb/tb_ifid_queue.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/ifid_queue_if.sv
// ifid_queue_if: fetch/decode handshake bundle for the IF/ID instruction queue.
interface ifid_queue_if;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_pc;
   logic [31:0] in_instr;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_pc;
   logic [31:0] out_instr;
   logic        out_is_ds;
   logic        out_exc_adel;
   logic        flush;
   modport master (
      output in_valid, in_pc, in_instr, out_ready, flush,
      input  in_ready, out_valid, out_pc, out_instr, out_is_ds, out_exc_adel
   );
   modport slave (
      input  in_valid, in_pc, in_instr, out_ready, flush,
      output in_ready, out_valid, out_pc, out_instr, out_is_ds, out_exc_adel
   );
endinterface

// File: rtl/ifid_queue.sv
// ifid_queue: 2-entry IF/ID FIFO tagging delay-slot instructions.
// Define IFQ_ADDR_CHECK_EN to flag misaligned fetch PCs as address errors.
module ifid_queue (
   input logic         clk,
   input logic         rst,
   ifid_queue_if.slave q
);
   logic [31:0] pcMem [2];
   logic [31:0] instrMem [2];
   logic [1:0]  dsMem;
   logic [1:0]  count;
   logic        rdPtr, wrPtr, lastBr;
   logic        enq, deq, isBr, misal;
   logic [5:0]  op, fn;
   logic [31:0] wrInstr;
   assign op = q.in_instr[31:26];
   assign fn = q.in_instr[5:0];
   assign isBr = (op >= 6'd1 && op <= 6'd7) || (op == 6'd0 && (fn == 6'h08 || fn == 6'h09));
`ifdef IFQ_ADDR_CHECK_EN
   logic [1:0] adelMem;
   assign misal = |q.in_pc[1:0];
   always_ff @(posedge clk)
      if (enq) adelMem[wrPtr] <= misal;
   assign q.out_exc_adel = q.out_valid & adelMem[rdPtr];
`else
   assign misal = 1'b0;
   assign q.out_exc_adel = 1'b0;
`endif
   assign wrInstr = misal ? 32'd0 : q.in_instr;
   assign q.in_ready = count < 2'd2;
   assign q.out_valid = count != 2'd0;
   assign enq = q.in_valid & q.in_ready;
   assign deq = q.out_valid & q.out_ready;
   assign q.out_pc = q.out_valid ? pcMem[rdPtr] : 32'd0;
   assign q.out_instr = q.out_valid ? instrMem[rdPtr] : 32'd0;
   assign q.out_is_ds = q.out_valid & dsMem[rdPtr];
   always_ff @(posedge clk)
      if (enq) begin
         pcMem[wrPtr] <= q.in_pc;
         instrMem[wrPtr] <= wrInstr;
         dsMem[wrPtr] <= lastBr;
      end
   // flush shares the reset path so it overrides any same-cycle transfer
   always_ff @(posedge clk)
      if (rst || q.flush) begin
         count <= 2'd0;
         rdPtr <= 1'b0;
         wrPtr <= 1'b0;
         lastBr <= 1'b0;
      end else begin
         count <= count + {1'b0, enq} - {1'b0, deq};
         if (enq) wrPtr <= ~wrPtr;
         if (deq) rdPtr <= ~rdPtr;
         if (enq && !misal) lastBr <= isBr;
      end
endmodule

// File: tb/tb_ifid_queue.sv
// tb_ifid_queue: scoreboard bench for ifid_queue (honours IFQ_ADDR_CHECK_EN).
module tb_ifid_queue;
   logic clk = 1'b0;
   logic rst;
   ifid_queue_if bus ();
   ifid_queue dut (.clk(clk), .rst(rst), .q(bus));
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
      logic        ds;
      logic        adel;
   } ent_t;
   ent_t sb[$];
   logic mLastBr;
   int errors = 0;
   int checks = 0;

   function automatic logic isBranch(input logic [31:0] i);
      logic [5:0] o;
      o = i[31:26];
      return (o >= 6'd1 && o <= 6'd7) || (o == 6'd0 && (i[5:0] == 6'h08 || i[5:0] == 6'h09));
   endfunction

   task automatic step(input logic iv, input logic [31:0] pc, input logic [31:0] instr,
                       input logic ordy, input logic fl, input logic r);
      ent_t e;
      logic en, de;
      @(negedge clk);
      rst = r;
      bus.in_valid = iv;
      bus.in_pc = pc;
      bus.in_instr = instr;
      bus.out_ready = ordy;
      bus.flush = fl;
      #1;
      checks++;
      if (bus.out_valid !== (sb.size() != 0)) begin
         errors++;
         $display("FAIL out_valid: got %b want %b", bus.out_valid, sb.size() != 0);
      end
      checks++;
      if (bus.in_ready !== (sb.size() < 2)) begin
         errors++;
         $display("FAIL in_ready: got %b want %b", bus.in_ready, sb.size() < 2);
      end
      if (sb.size() == 0) begin
         e.pc = 32'd0; e.instr = 32'd0; e.ds = 1'b0; e.adel = 1'b0;
      end else e = sb[0];
      checks++;
      if ({bus.out_pc, bus.out_instr, bus.out_is_ds, bus.out_exc_adel} !== {e.pc, e.instr, e.ds, e.adel}) begin
         errors++;
         $display("FAIL head: got pc=%h instr=%h ds=%b adel=%b want pc=%h instr=%h ds=%b adel=%b",
                  bus.out_pc, bus.out_instr, bus.out_is_ds, bus.out_exc_adel, e.pc, e.instr, e.ds, e.adel);
      end
      if (r || fl) begin
         sb.delete();
         mLastBr = 1'b0;
      end else begin
         en = iv && sb.size() < 2;
         de = ordy && sb.size() != 0;
         if (de) void'(sb.pop_front());
         if (en) begin
            e.pc = pc; e.instr = instr; e.ds = mLastBr; e.adel = 1'b0;
`ifdef IFQ_ADDR_CHECK_EN
            if (pc[1:0] != 2'b00) begin
               e.instr = 32'd0;
               e.adel = 1'b1;
            end else mLastBr = isBranch(instr);
`else
            mLastBr = isBranch(instr);
`endif
            sb.push_back(e);
         end
      end
      @(posedge clk);
   endtask

   task automatic idle(input int n, input logic ordy);
      for (int i = 0; i < n; i++) step(1'b0, 32'd0, 32'd0, ordy, 1'b0, 1'b0);
   endtask

   task automatic test_reset;
      rst = 1'b1;
      bus.in_valid = 1'b0; bus.in_pc = 32'd0; bus.in_instr = 32'd0;
      bus.out_ready = 1'b0; bus.flush = 1'b0;
      sb.delete();
      mLastBr = 1'b0;
      repeat (2) @(posedge clk);
      idle(3, 1'b0);
   endtask

   task automatic test_ds_order;
      step(1'b1, 32'hBFC00000, 32'h10000003, 1'b0, 1'b0, 1'b0);
      step(1'b1, 32'hBFC00004, 32'h24020001, 1'b0, 1'b0, 1'b0);
      step(1'b1, 32'hBFC00008, 32'h00000000, 1'b0, 1'b0, 1'b0);
      idle(2, 1'b0);
      step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0);
      #1;
      checks++;
      if (bus.out_pc !== 32'hBFC00004 || bus.out_is_ds !== 1'b1) begin
         errors++;
         $display("FAIL ds_second: got pc=%h ds=%b want pc=bfc00004 ds=1", bus.out_pc, bus.out_is_ds);
      end
      idle(2, 1'b1);
   endtask

   task automatic test_back_to_back;
      step(1'b1, 32'h00001000, 32'h24000000, 1'b0, 1'b0, 1'b0);
      for (int i = 1; i <= 10; i++)
         step(1'b1, 32'h00001000 + 32'(i * 4), (i % 3 == 0) ? 32'h03E00008 : 32'h24000000 + 32'(i), 1'b1, 1'b0, 1'b0);
      idle(2, 1'b1);
   endtask

   task automatic test_flush;
      step(1'b1, 32'h00002000, 32'h24000011, 1'b0, 1'b0, 1'b0);
      step(1'b1, 32'h00002004, 32'h0C000100, 1'b0, 1'b0, 1'b0);
      step(1'b1, 32'h00002008, 32'h24000022, 1'b1, 1'b1, 1'b0);
      step(1'b1, 32'h00003000, 32'h24000033, 1'b0, 1'b0, 1'b0);
      #1;
      checks++;
      if (bus.out_pc !== 32'h00003000 || bus.out_is_ds !== 1'b0) begin
         errors++;
         $display("FAIL flush_ds: got pc=%h ds=%b want pc=00003000 ds=0", bus.out_pc, bus.out_is_ds);
      end
      idle(2, 1'b1);
   endtask

   task automatic test_addr;
      step(1'b1, 32'hBFC00002, 32'h08000000, 1'b0, 1'b0, 1'b0);
      step(1'b1, 32'hBFC00008, 32'h24020001, 1'b0, 1'b0, 1'b0);
      #1;
      checks++;
`ifdef IFQ_ADDR_CHECK_EN
      if (bus.out_exc_adel !== 1'b1 || bus.out_instr !== 32'd0) begin
         errors++;
         $display("FAIL adel: got adel=%b instr=%h want adel=1 instr=00000000", bus.out_exc_adel, bus.out_instr);
      end
`else
      if (bus.out_exc_adel !== 1'b0 || bus.out_instr !== 32'h08000000) begin
         errors++;
         $display("FAIL adel: got adel=%b instr=%h want adel=0 instr=08000000", bus.out_exc_adel, bus.out_instr);
      end
`endif
      idle(3, 1'b1);
   endtask

   task automatic test_reset_mid;
      step(1'b1, 32'h00004000, 32'h10000001, 1'b0, 1'b0, 1'b0);
      step(1'b1, 32'h00004004, 32'h24000044, 1'b0, 1'b0, 1'b0);
      step(1'b1, 32'h00004008, 32'h24000055, 1'b1, 1'b1, 1'b1);
      idle(1, 1'b1);
      step(1'b1, 32'h00005000, 32'h24000066, 1'b0, 1'b0, 1'b0);
      idle(2, 1'b1);
   endtask

   initial begin
      test_reset;
      test_ds_order;
      test_back_to_back;
      test_flush;
      test_addr;
      test_reset_mid;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
